rcs_seq_addsub: RTL

Parametrised, multi-cycle ripple-carry adder/subtractor. It processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, and carries the ripple between slices through a register. It generalises the fixed-width combinational ripple subtractor in two ways: a runtime add/sub mode and a valid/ready handshake on both sides. It sits in the arithmetic datapath wherever area matters more than single-cycle latency.

---
 rtl/rcs_pkg.sv | 16 +
 rtl/rcs_slice.sv | 31 +++
 rtl/rcs_seq_addsub.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rcs_pkg.sv
// rcs_pkg: shared types and constants for the sequential ripple-carry
// adder/subtractor (rcs_seq_addsub) and its slice adder (rcs_slice).
//   state_e  - control FSM states
//   MODE_ADD / MODE_SUB - values of the 'mode' input
package rcs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/rcs_slice.sv
// rcs_slice: combinational CHUNK-bit ripple chain of full adders.
// Ports:
//   a, b   [CHUNK-1:0] in   slice operands (b already inverted for subtract)
//   cin            in   carry into bit 0
//   sum    [CHUNK-1:0] out  slice sum
//   cout           out  carry out of the slice MSB
//   c_msb          out  carry into the slice MSB (signed-overflow detection)
module rcs_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/rcs_seq_addsub.sv
// rcs_seq_addsub: multi-cycle ripple-carry adder/subtractor. A WIDTH-bit
// operand pair is processed CHUNK bits per clock; the inter-slice carry lives
// in a register. Result is ready NSLICE = WIDTH/CHUNK cycles after accept.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (accept only in IDLE)
//   mode                0 = a+b, 1 = a-b (sampled on accept)
//   a, b   [WIDTH-1:0]  operands (sampled on accept)
//   out_valid/out_ready result handshake (held in DONE until out_ready)
//   sum    [WIDTH-1:0]  result modulo 2^WIDTH
//   carry               carry out of MSB (sub: 1 = no borrow)
//   ovf                 signed overflow; only computed when RCS_OVERFLOW_EN
//                       is defined, otherwise tied to 0
// Build option: `define RCS_OVERFLOW_EN to enable overflow detection.
module rcs_seq_addsub
  import rcs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  state_e            state_q, state_d;
  logic              rdy_q;      // low until the first edge after reset release
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              cy_q;
  logic              accept;

  logic [CHUNK-1:0]  s_sum;
  logic              s_cout;

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign sum       = sum_q;
  assign carry     = cy_q;

  // ---- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = BUSY;
      BUSY:    if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // ---- slice adder on the current chunk ----
`ifdef RCS_OVERFLOW_EN
  logic s_cmsb;
`endif

  rcs_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (a_q[int'(idx_q)*CHUNK +: CHUNK]),
    .b     (b_q[int'(idx_q)*CHUNK +: CHUNK]),
    .cin   (cy_q),
    .sum   (s_sum),
    .cout  (s_cout),
`ifdef RCS_OVERFLOW_EN
    .c_msb (s_cmsb)
`else
    .c_msb ()
`endif
  );

  // ---- datapath ----
  // b is stored pre-inverted and the carry seeded with mode, so subtract is
  // a + ~b + 1 through the same ripple chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cy_q  <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= (mode == MODE_SUB) ? ~b : b;
      cy_q  <= mode;
      idx_q <= '0;
    end else if (state_q == BUSY) begin
      sum_q[int'(idx_q)*CHUNK +: CHUNK] <= s_sum;
      cy_q  <= s_cout;
      idx_q <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef RCS_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 ovf_q <= 1'b0;
    else if (accept)                            ovf_q <= 1'b0;
    else if (state_q == BUSY && idx_q == LAST)  ovf_q <= s_cmsb ^ s_cout;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
